// File: rtl/conv_pkg.sv
// conv_pkg: constants and helpers shared by the 2x2 window generator and the
// 2x2 convolution core (pixel width, window width, window lane order).
package conv_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int WIN_W       = 4 * DATA_W_DFLT;

    // Window lane indices: lane n occupies bits [n*DATA_W +: DATA_W]
    localparam int TL = 3;
    localparam int TR = 2;
    localparam int BL = 1;
    localparam int BR = 0;

    // Pack four pixels into the core's image-operand word, top-left in MSBs
    function automatic logic [WIN_W-1:0] pack_win(
        input logic [DATA_W_DFLT-1:0] tl,
        input logic [DATA_W_DFLT-1:0] tr,
        input logic [DATA_W_DFLT-1:0] bl,
        input logic [DATA_W_DFLT-1:0] br
    );
        logic [WIN_W-1:0] w;
        w = '0;
        w[TL*DATA_W_DFLT +: DATA_W_DFLT] = tl;
        w[TR*DATA_W_DFLT +: DATA_W_DFLT] = tr;
        w[BL*DATA_W_DFLT +: DATA_W_DFLT] = bl;
        w[BR*DATA_W_DFLT +: DATA_W_DFLT] = br;
        return w;
    endfunction

endpackage

// File: rtl/win_gen_linebuf.sv
// win_gen_linebuf: one image row of pixels. Combinational read of the current
// address; the write of the same address lands on the clock edge, so a read in
// the write cycle returns the previous row's pixel. Contents are not reset.
module win_gen_linebuf #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read is asynchronous: the caller samples it in the same cycle it writes
    always_comb begin
        rd_data = mem[addr];
    end

    // Row storage update on every accepted pixel
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/win_gen_2x2.sv
// win_gen_2x2: turns a row-major pixel stream into 2x2 windows for the conv
// core. One row is buffered; the window's top row comes from the line buffer
// and the bottom row from the live stream. Output is a registered valid/ready
// stage with no skid buffer, so pix_ready follows win_ready combinationally.
// Build option: define WIN_GEN_STRIDE2_EN for non-overlapping (stride 2) tiles.
module win_gen_2x2
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   pix_in,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [4*DATA_W-1:0] win_out,
    output logic                win_valid,
    input  logic                win_ready,
    output logic                win_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

`ifdef WIN_GEN_STRIDE2_EN
    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_odd_dims
        $error("win_gen_2x2: stride-2 tiling needs even IMG_W and IMG_H");
    end
`endif

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DATA_W-1:0]   tl_q;      // lb[c-1] captured on the previous accept
    logic [DATA_W-1:0]   bl_q;      // previous accepted pixel
    logic [DATA_W-1:0]   lb_rd;
    logic [4*DATA_W-1:0] win_q, win_d;
    logic                valid_q, last_q;
    logic                accept, form, last_d;

    win_gen_linebuf #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .AW     (CW)
    ) u_lb (
        .clk     (clk),
        .addr    (col_q),
        .wr_en   (accept),
        .wr_data (pix_in),
        .rd_data (lb_rd)
    );

    // Handshake and window formation for the pixel on the input this cycle
    always_comb begin
        pix_ready = !valid_q || win_ready;
        accept    = pix_valid && pix_ready;
`ifdef WIN_GEN_STRIDE2_EN
        form      = accept && row_q[0] && col_q[0];
`else
        form      = accept && (row_q != '0) && (col_q != '0);
`endif
        last_d    = (row_q == ROW_MAX) && (col_q == COL_MAX);
        win_d     = '0;
        win_d[TL*DATA_W +: DATA_W] = tl_q;
        win_d[TR*DATA_W +: DATA_W] = lb_rd;
        win_d[BL*DATA_W +: DATA_W] = bl_q;
        win_d[BR*DATA_W +: DATA_W] = pix_in;
    end

    // Raster position: column then row, both wrap at frame end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counters, pixel history and the output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            tl_q    <= '0;
            bl_q    <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (accept) begin
                tl_q <= lb_rd;
                bl_q <= pix_in;
            end
            if (form) begin
                win_q   <= win_d;
                valid_q <= 1'b1;
                last_q  <= last_d;
            end else if (win_ready) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign win_out   = win_q;
    assign win_valid = valid_q;
    assign win_last  = last_q;

endmodule

// File: tb/tb_win_gen_2x2.sv
// tb_win_gen_2x2: two generators (a small frame and a 4x4 frame) driven with
// directed and randomized pixel streams and random back-pressure. Expected
// windows are cut straight out of the 2D image of each frame.
module tb_win_gen_2x2;

`ifdef WIN_GEN_STRIDE2_EN
    localparam bit S2  = 1'b1;
    localparam int A_W = 4;
    localparam int A_H = 2;
`else
    localparam bit S2  = 1'b0;
    localparam int A_W = 3;
    localparam int A_H = 3;
`endif
    localparam int B_W = 4;
    localparam int B_H = 4;

    typedef logic [7:0] pq_t[$];
    typedef struct { logic [31:0] w; logic last; } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  pin [2];
    logic        pv  [2];
    logic        pr  [2];
    logic [31:0] wo  [2];
    logic        wv  [2];
    logic        wr  [2];
    logic        wl  [2];

    exp_t        exp_q[$];
    logic [31:0] obs_q[$];
    logic        obs_last_q[$];
    int          checks = 0;
    int          passes = 0;
    int          cycles_used;
    int          stalls;
    logic [31:0] first_held;

    win_gen_2x2 #(.IMG_W(A_W), .IMG_H(A_H), .DATA_W(8)) u_a (
        .clk(clk), .rst(rst), .pix_in(pin[0]), .pix_valid(pv[0]), .pix_ready(pr[0]),
        .win_out(wo[0]), .win_valid(wv[0]), .win_ready(wr[0]), .win_last(wl[0]));

    win_gen_2x2 #(.IMG_W(B_W), .IMG_H(B_H), .DATA_W(8)) u_b (
        .clk(clk), .rst(rst), .pix_in(pin[1]), .pix_valid(pv[1]), .pix_ready(pr[1]),
        .win_out(wo[1]), .win_valid(wv[1]), .win_ready(wr[1]), .win_last(wl[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int get_w(input int s);
        return (s == 0) ? A_W : B_W;
    endfunction

    function automatic int get_h(input int s);
        return (s == 0) ? A_H : B_H;
    endfunction

    function automatic pq_t seq(input int base, input int n);
        pq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(base + i));
        return q;
    endfunction

    function automatic pq_t rnd(input int n);
        pq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: every 2x2 window of each frame image, in raster order
    task automatic model(input int s, input pq_t px);
        int w, h, o;
        exp_t e;
        w = get_w(s);
        h = get_h(s);
        exp_q.delete();
        for (int f = 0; f < px.size() / (w * h); f++) begin
            o = f * w * h;
            for (int r = 1; r < h; r++) begin
                for (int c = 1; c < w; c++) begin
                    if (S2 && !((r % 2 == 1) && (c % 2 == 1))) continue;
                    e.w = {px[o + (r-1)*w + c-1], px[o + (r-1)*w + c],
                           px[o + r*w + c-1],     px[o + r*w + c]};
                    e.last = (r == h - 1) && (c == w - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Stream px into DUT s; vp/rp are valid/ready percentages; stall_n holds
    // win_ready low that many cycles once the first window shows up.
    task automatic run(input int s, input pq_t px, input int vp, input int rp, input int stall_n);
        int idx = 0;
        int cyc = 0;
        int scnt = 0;
        bit started = 1'b0;
        exp_t e;
        model(s, px);
        obs_q.delete();
        obs_last_q.delete();
        stalls = 0;
        while ((idx < px.size() || exp_q.size() != 0) && cyc < 3000) begin
            pv[s]  = (idx < px.size()) && ($urandom_range(99) < vp);
            pin[s] = (idx < px.size()) ? px[idx] : 8'h00;
            if (stall_n > 0 && !started && wv[s]) begin
                started    = 1'b1;
                scnt       = stall_n;
                first_held = wo[s];
            end
            wr[s] = (scnt > 0) ? 1'b0 : ($urandom_range(99) < rp);
            @(negedge clk);
            if (scnt > 0) begin
                checks++;
                if (wo[s] !== first_held || wv[s] !== 1'b1 || pr[s] !== 1'b0)
                    $display("FAIL stall_hold: got win=%h valid=%b ready=%b, want win=%h valid=1 ready=0",
                             wo[s], wv[s], pr[s], first_held);
                else passes++;
                scnt--;
            end
            checks++;
            if (pr[s] !== (!wv[s] || wr[s]))
                $display("FAIL pix_ready: got %b want %b", pr[s], (!wv[s] || wr[s]));
            else passes++;
            if (pv[s] && !pr[s]) stalls++;
            if (pv[s] && pr[s]) idx++;
            if (wv[s] && wr[s]) begin
                obs_q.push_back(wo[s]);
                obs_last_q.push_back(wl[s]);
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_window: got %h want none", wo[s]);
                end else begin
                    e = exp_q.pop_front();
                    if (wo[s] !== e.w || wl[s] !== e.last)
                        $display("FAIL window: got %h last=%b want %h last=%b", wo[s], wl[s], e.w, e.last);
                    else passes++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        pv[s] = 1'b0;
        wr[s] = 1'b1;
        cycles_used = cyc;
        checks++;
        if (idx != px.size() || exp_q.size() != 0)
            $display("FAIL drain: got %0d pixels sent %0d windows left, want %0d sent 0 left",
                     idx, exp_q.size(), px.size());
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            pv[s] = 1'b0; pin[s] = 8'h00; wr[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (wv[s] !== 1'b0 || wl[s] !== 1'b0 || wo[s] !== 32'h0 || pr[s] !== 1'b1)
                $display("FAIL reset_state: got valid=%b last=%b win=%h ready=%b want 0 0 0 1",
                         wv[s], wl[s], wo[s], pr[s]);
            else passes++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int nlast;
        logic [31:0] ref3 [4];
        ref3[0] = 32'h01020405; ref3[1] = 32'h02030506;
        ref3[2] = 32'h04050708; ref3[3] = 32'h05060809;
        run(0, seq(1, A_W * A_H), 100, 100, 0);
        nlast = 0;
        foreach (obs_last_q[i]) if (obs_last_q[i] === 1'b1) nlast++;
        checks++;
        if (nlast != 1 || obs_last_q.size() == 0 || obs_last_q[obs_last_q.size()-1] !== 1'b1)
            $display("FAIL basic_last: got %0d lasts want exactly 1 on final window", nlast);
        else passes++;
        if (!S2) begin
            checks++;
            if (obs_q.size() != 4)
                $display("FAIL basic_count: got %0d want 4", obs_q.size());
            else passes++;
            for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== ref3[i])
                    $display("FAIL basic_win%0d: got %h want %h", i, obs_q[i], ref3[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_stall();
        run(0, seq(1, A_W * A_H), 100, 100, 5);
        if (!S2) begin
            checks++;
            if (first_held !== 32'h01020405 || obs_q.size() != 4 || obs_q[3] !== 32'h05060809)
                $display("FAIL stall_seq: got held=%h n=%0d want held=01020405 n=4", first_held, obs_q.size());
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        pq_t px;
        px = seq(1, A_W * A_H);
        px = {px, seq(11, A_W * A_H)};
        run(0, px, 100, 100, 0);
        if (!S2) begin
            checks++;
            if (obs_q.size() != 8 || obs_q[4] !== 32'h0b0c0e0f)
                $display("FAIL b2b_frame2: got n=%0d first=%h want n=8 first=0b0c0e0f",
                         obs_q.size(), (obs_q.size() > 4) ? obs_q[4] : 32'h0);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        // A_W+2 pixels reaches position (1,1), which loads a window in both modes
        for (int i = 0; i < A_W + 2; i++) begin
            pv[0] = 1'b1; pin[0] = 8'(i + 1); wr[0] = 1'b1;
            @(posedge clk);
            #1;
        end
        pv[0] = 1'b0; wr[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wv[0] !== 1'b1)
            $display("FAIL mid_pending: got valid=%b want 1", wv[0]);
        else passes++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wv[0] !== 1'b0 || wo[0] !== 32'h0 || wl[0] !== 1'b0)
            $display("FAIL mid_reset: got valid=%b win=%h want valid=0 win=0", wv[0], wo[0]);
        else passes++;
        @(posedge clk);
        #1;
        run(0, seq(1, A_W * A_H), 100, 100, 0);
        if (!S2) begin
            checks++;
            if (obs_q.size() != 4 || obs_q[0] !== 32'h01020405)
                $display("FAIL mid_clean: got n=%0d first=%h want n=4 first=01020405",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'h0);
            else passes++;
        end
    endtask

    task automatic test_continuous();
        int nwin;
        nwin = S2 ? (B_W / 2) * (B_H / 2) : (B_W - 1) * (B_H - 1);
        run(1, seq(1, B_W * B_H), 100, 100, 0);
        checks++;
        if (obs_q.size() != nwin || stalls != 0 || cycles_used != B_W * B_H + 1)
            $display("FAIL continuous: got n=%0d stalls=%0d cycles=%0d want n=%0d stalls=0 cycles=%0d",
                     obs_q.size(), stalls, cycles_used, nwin, B_W * B_H + 1);
        else passes++;
        if (S2) begin
            checks++;
            if (obs_q.size() != 4 || obs_q[0] !== 32'h01020506 || obs_q[1] !== 32'h03040708 ||
                obs_q[2] !== 32'h090a0d0e || obs_q[3] !== 32'h0b0c0f10 || obs_last_q[3] !== 1'b1)
                $display("FAIL stride2_tiles: got n=%0d first=%h want 4 tiles from 01020506",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'h0);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            run(s, rnd(3 * get_w(s) * get_h(s)), 70, 60, 0);
            run(s, rnd(2 * get_w(s) * get_h(s)), 40, 90, 3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_continuous();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
